ysyx_22050710_inst_axi_bridge: RTL and testbench

Upstream neighbour of the IF stage. Terminates the instruction-SRAM-like interface (ren/addr → addr_ok, then data_ok/rdata) and converts each accepted fetch into one AXI4 read burst (single beat) on a dedicated instruction master port. It allows at most one outstanding transaction, and it registers the returned beat so the fetch data stays stable after data_ok.

---
 rtl/ysyx_22050710_inst_axi_bridge_pkg.sv | 14 +
 rtl/ysyx_22050710_inst_axi_bridge_if.sv | 46 ++++
 rtl/ysyx_22050710_inst_axi_bridge_reg.sv | 16 +
 rtl/ysyx_22050710_inst_axi_bridge.sv | 77 +++++++
 tb/tb_ysyx_22050710_inst_axi_bridge.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050710_inst_axi_bridge_pkg.sv
// Shared AXI constants and bridge FSM encodings, reused by the data-side bridge and arbiter.
package ysyx_22050710_inst_axi_bridge_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_e;

endpackage

// File: rtl/ysyx_22050710_inst_axi_bridge_if.sv
// Instruction-SRAM-like fetch port plus the AXI4 read channels of the instruction master.
interface ysyx_22050710_inst_axi_bridge_if #(
  parameter int SRAM_ADDR_WD = 32,
  parameter int SRAM_DATA_WD = 64,
  parameter int AXI_ID_WD    = 4
);
  logic                    inst_sram_ren;
  logic [SRAM_ADDR_WD-1:0] inst_sram_addr;
  logic                    inst_sram_addr_ok;
  logic                    inst_sram_data_ok;
  logic [SRAM_DATA_WD-1:0] inst_sram_rdata;
  logic                    inst_sram_err;

  logic                    axi_arvalid;
  logic                    axi_arready;
  logic [SRAM_ADDR_WD-1:0] axi_araddr;
  logic [AXI_ID_WD-1:0]    axi_arid;
  logic [7:0]              axi_arlen;
  logic [2:0]              axi_arsize;
  logic [1:0]              axi_arburst;
  logic                    axi_rvalid;
  logic                    axi_rready;
  logic [SRAM_DATA_WD-1:0] axi_rdata;
  logic [1:0]              axi_rresp;
  logic                    axi_rlast;

  // Bridge side: fetch slave, AXI read master.
  modport master (
    input  inst_sram_ren, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, inst_sram_err,
    output axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst,
    input  axi_arready,
    input  axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
    output axi_rready
  );

  // Environment side: IF stage plus AXI slave.
  modport slave (
    output inst_sram_ren, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, inst_sram_err,
    input  axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst,
    output axi_arready,
    output axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
    input  axi_rready
  );
endinterface

// File: rtl/ysyx_22050710_inst_axi_bridge_reg.sv
// Common register primitive: synchronous active-high reset, write enable.
module ysyx_22050710_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wen_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);
  always_ff @(posedge clk_i) begin
    if (rst_i)      dout_o <= RESET_VAL;
    else if (wen_i) dout_o <= din_i;
  end
endmodule

// File: rtl/ysyx_22050710_inst_axi_bridge.sv
// Fetch-to-AXI4 read bridge: one single-beat burst per accepted fetch, one outstanding.
// state | meaning
// IDLE  | no transaction outstanding, fetch can be accepted
// AR    | address phase, arvalid high until arready
// R     | waiting for the read beat; accepting a new fetch alongside it
module ysyx_22050710_inst_axi_bridge
  import ysyx_22050710_inst_axi_bridge_pkg::*;
#(
  parameter int SRAM_ADDR_WD = 32,
  parameter int SRAM_DATA_WD = 64,
  parameter int AXI_ID_WD    = 4,
  parameter int AXI_ID       = 0
) (
  input logic i_clk,
  input logic i_rst,
  ysyx_22050710_inst_axi_bridge_if.master bus
);
  logic                    rst_h;
  state_e                  state_q, state_d;
  logic [1:0]              state_raw_q;
  logic                    addr_ok;
  logic                    r_fire;
  logic                    err_d;
  logic [SRAM_ADDR_WD-1:0] araddr_d, araddr_q;
  logic [SRAM_DATA_WD-1:0] rdata_q;
  logic                    data_ok_q, err_q;
  logic                    unused_bits;

  assign rst_h       = ~i_rst;
  assign state_q     = state_e'(state_raw_q);
  assign unused_bits = &{1'b0, bus.axi_rlast, bus.inst_sram_addr[2:0]};

  always_comb begin
    state_d = state_q;
    r_fire  = (state_q == R) && bus.axi_rvalid;
    // Gated by reset so nothing is accepted while the FSM is being cleared.
    addr_ok = i_rst && bus.inst_sram_ren && ((state_q == IDLE) || r_fire);
    case (state_q)
      IDLE:    if (addr_ok) state_d = AR;
      AR:      if (bus.axi_arready) state_d = R;
      R:       if (r_fire) state_d = addr_ok ? AR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat alignment only; the 4-byte word select happens downstream.
  assign araddr_d = {bus.inst_sram_addr[SRAM_ADDR_WD-1:3], 3'b000};
  assign err_d    = r_fire && (bus.axi_rresp != RESP_OKAY);

  ysyx_22050710_reg #(.WIDTH(2), .RESET_VAL(IDLE)) u_state (
    .clk_i(i_clk), .rst_i(rst_h), .wen_i(1'b1), .din_i(state_d), .dout_o(state_raw_q));

  ysyx_22050710_reg #(.WIDTH(SRAM_ADDR_WD), .RESET_VAL('0)) u_araddr (
    .clk_i(i_clk), .rst_i(rst_h), .wen_i(addr_ok), .din_i(araddr_d), .dout_o(araddr_q));

  ysyx_22050710_reg #(.WIDTH(SRAM_DATA_WD), .RESET_VAL('0)) u_rdata (
    .clk_i(i_clk), .rst_i(rst_h), .wen_i(r_fire), .din_i(bus.axi_rdata), .dout_o(rdata_q));

  ysyx_22050710_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_data_ok (
    .clk_i(i_clk), .rst_i(rst_h), .wen_i(1'b1), .din_i(r_fire), .dout_o(data_ok_q));

  ysyx_22050710_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_err (
    .clk_i(i_clk), .rst_i(rst_h), .wen_i(1'b1), .din_i(err_d), .dout_o(err_q));

  assign bus.inst_sram_addr_ok = addr_ok;
  assign bus.inst_sram_data_ok = data_ok_q;
  assign bus.inst_sram_rdata   = rdata_q;
  assign bus.inst_sram_err     = err_q;

  assign bus.axi_arvalid = (state_q == AR);
  assign bus.axi_araddr  = araddr_q;
  assign bus.axi_arid    = AXI_ID_WD'(AXI_ID);
  assign bus.axi_arlen   = 8'd0;
  assign bus.axi_arsize  = SIZE_8B;
  assign bus.axi_arburst = BURST_INCR;
  assign bus.axi_rready  = (state_q == R);
endmodule

// File: tb/tb_ysyx_22050710_inst_axi_bridge.sv
// Directed bench for the instruction AXI bridge with a transaction-level reference model.
module tb_ysyx_22050710_inst_axi_bridge;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   dok_seen = 0;

  always #5 clk = ~clk;

  ysyx_22050710_inst_axi_bridge_if #(.SRAM_ADDR_WD(32), .SRAM_DATA_WD(64), .AXI_ID_WD(4)) bus ();

  ysyx_22050710_inst_axi_bridge #(
    .SRAM_ADDR_WD(32), .SRAM_DATA_WD(64), .AXI_ID_WD(4), .AXI_ID(0)
  ) u_dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus, applied just after the rising edge.
  task automatic cyc(input logic r, input logic ren, input logic [31:0] addr, input logic arr,
                     input logic rv, input logic [63:0] rd, input logic [1:0] resp);
    @(posedge clk);
    #1;
    rst_n              = r;
    bus.inst_sram_ren  = ren;
    bus.inst_sram_addr = addr;
    bus.axi_arready    = arr;
    bus.axi_rvalid     = rv;
    bus.axi_rdata      = rd;
    bus.axi_rresp      = resp;
    bus.axi_rlast      = 1'b1;
    #1;
  endtask

  // Reference model: a fetch is either absent, waiting on its address handshake, or waiting on its beat.
  bit          m_busy = 0;
  bit          m_ar_done = 0;
  bit          m_dok = 0;
  bit          m_err = 0;
  logic [63:0] m_rdata = '0;
  logic [31:0] m_q[$];
  bit          m_aok;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      m_aok = rst_n && bus.inst_sram_ren && (!m_busy || (m_ar_done && bus.axi_rvalid));
      chk("addr_ok", bus.inst_sram_addr_ok, m_aok);
      chk("arvalid", bus.axi_arvalid, m_busy && !m_ar_done);
      if (m_busy && !m_ar_done) chk("araddr", bus.axi_araddr, m_q[0]);
      chk("rready", bus.axi_rready, m_busy && m_ar_done);
      chk("data_ok", bus.inst_sram_data_ok, m_dok);
      chk("err", bus.inst_sram_err, m_err);
      chk("rdata", bus.inst_sram_rdata, m_rdata);
      if (bus.inst_sram_data_ok === 1'b1) dok_seen++;
      if (!rst_n) begin
        m_busy = 0; m_ar_done = 0; m_dok = 0; m_err = 0; m_rdata = '0;
        m_q.delete();
      end else begin
        m_dok = m_busy && m_ar_done && bus.axi_rvalid;
        m_err = 0;
        if (m_dok) begin
          m_rdata = bus.axi_rdata;
          m_err   = (bus.axi_rresp != 2'b00);
          void'(m_q.pop_front());
          m_busy = 0;
          m_ar_done = 0;
        end else if (m_busy && !m_ar_done && bus.axi_arready) begin
          m_ar_done = 1;
        end
        if (m_aok) begin
          m_q.push_back(bus.inst_sram_addr & ~32'h7);
          m_busy = 1;
          m_ar_done = 0;
        end
      end
    end
  end

  localparam logic [63:0] D0 = 64'h0000_0013_0000_0093;
  localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D3 = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] D4 = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] D5 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D6 = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] D7 = 64'h0000_0073_0010_0513;

  initial begin
    rst_n = 1'b0;
    bus.inst_sram_ren = 1'b1; bus.inst_sram_addr = 32'h8000_0004;
    bus.axi_arready = 1'b0; bus.axi_rvalid = 1'b0; bus.axi_rdata = '0;
    bus.axi_rresp = 2'b00; bus.axi_rlast = 1'b1;

    // Reset held with a pending request
    repeat (3) begin
      cyc(0, 1, 32'h8000_0004, 1, 0, '0, 0);
      chk("rst_addr_ok", bus.inst_sram_addr_ok, 0);
      chk("rst_arvalid", bus.axi_arvalid, 0);
      chk("rst_data_ok", bus.inst_sram_data_ok, 0);
      chk("rst_rdata", bus.inst_sram_rdata, 0);
    end
    chk("arid", bus.axi_arid, 4'd0);
    chk("arlen", bus.axi_arlen, 8'd0);
    chk("arsize", bus.axi_arsize, 3'b011);
    chk("arburst", bus.axi_arburst, 2'b01);

    // Single fetch, zero-wait slave; release cycle is T
    cyc(1, 1, 32'h8000_0004, 1, 0, '0, 0);
    chk("release_addr_ok", bus.inst_sram_addr_ok, 1);
    cyc(1, 0, 32'h0, 1, 0, '0, 0);
    chk("t1_arvalid", bus.axi_arvalid, 1);
    chk("t1_araddr", bus.axi_araddr, 32'h8000_0000);
    cyc(1, 0, 32'h0, 1, 1, D0, 0);
    chk("t2_rready", bus.axi_rready, 1);
    cyc(1, 0, 32'h0, 0, 0, '0, 0);
    chk("t3_data_ok", bus.inst_sram_data_ok, 1);
    chk("t3_rdata", bus.inst_sram_rdata, D0);
    chk("t3_err", bus.inst_sram_err, 0);

    // Back-to-back
    cyc(1, 1, 32'h8000_0000, 1, 0, '0, 0);
    chk("b2b_first_addr_ok", bus.inst_sram_addr_ok, 1);
    cyc(1, 1, 32'h8000_0008, 1, 0, '0, 0);
    chk("b2b_stall_in_ar", bus.inst_sram_addr_ok, 0);
    cyc(1, 1, 32'h8000_0008, 1, 1, D1, 0);
    chk("b2b_second_addr_ok", bus.inst_sram_addr_ok, 1);
    cyc(1, 0, 32'h0, 1, 0, '0, 0);
    chk("b2b_dok1", bus.inst_sram_data_ok, 1);
    chk("b2b_rdata1", bus.inst_sram_rdata, D1);
    chk("b2b_araddr2", bus.axi_araddr, 32'h8000_0008);
    cyc(1, 0, 32'h0, 1, 1, D2, 0);
    chk("b2b_gap", bus.inst_sram_data_ok, 0);
    cyc(1, 0, 32'h0, 0, 0, '0, 0);
    chk("b2b_dok2", bus.inst_sram_data_ok, 1);
    chk("b2b_rdata2", bus.inst_sram_rdata, D2);

    // Backpressure on AR then on R
    cyc(1, 1, 32'h8000_0010, 0, 0, '0, 0);
    repeat (4) begin
      cyc(1, 1, 32'h8000_0018, 0, 0, '0, 0);
      chk("bp_arvalid", bus.axi_arvalid, 1);
      chk("bp_araddr", bus.axi_araddr, 32'h8000_0010);
    end
    cyc(1, 1, 32'h8000_0018, 1, 0, '0, 0);
    repeat (5) begin
      cyc(1, 1, 32'h8000_0018, 0, 0, '0, 0);
      chk("bp_busy_addr_ok", bus.inst_sram_addr_ok, 0);
    end
    cyc(1, 0, 32'h0, 0, 1, D3, 0);
    cyc(1, 0, 32'h0, 0, 0, '0, 0);
    chk("bp_dok", bus.inst_sram_data_ok, 1);
    chk("bp_rdata", bus.inst_sram_rdata, D3);
    cyc(1, 0, 32'h0, 0, 0, '0, 0);
    chk("bp_single_dok", bus.inst_sram_data_ok, 0);

    // ren dropped after acceptance
    cyc(1, 1, 32'h8000_0020, 1, 0, '0, 0);
    cyc(1, 0, 32'h0, 1, 0, '0, 0);
    cyc(1, 0, 32'h0, 0, 1, D4, 0);
    cyc(1, 0, 32'h0, 0, 0, '0, 0);
    chk("drop_dok", bus.inst_sram_data_ok, 1);
    repeat (3) cyc(1, 0, 32'h0, 0, 0, '0, 0);
    chk("drop_rdata_held", bus.inst_sram_rdata, D4);
    chk("drop_idle", bus.axi_arvalid, 0);

    // SLVERR response
    cyc(1, 1, 32'h8000_0028, 1, 0, '0, 0);
    cyc(1, 0, 32'h0, 1, 0, '0, 0);
    cyc(1, 0, 32'h0, 0, 1, D5, 2'b10);
    cyc(1, 0, 32'h0, 0, 0, '0, 0);
    chk("err_dok", bus.inst_sram_data_ok, 1);
    chk("err_flag", bus.inst_sram_err, 1);
    chk("err_rdata", bus.inst_sram_rdata, D5);

    // Reset while in AR, then a stray rvalid in IDLE
    cyc(1, 1, 32'h8000_0030, 0, 0, '0, 0);
    cyc(1, 0, 32'h0, 0, 0, '0, 0);
    chk("midrst_in_ar", bus.axi_arvalid, 1);
    cyc(0, 0, 32'h0, 0, 0, '0, 0);
    cyc(1, 0, 32'h0, 0, 1, D6, 0);
    chk("midrst_arvalid", bus.axi_arvalid, 0);
    chk("midrst_rready", bus.axi_rready, 0);
    cyc(1, 0, 32'h0, 0, 0, '0, 0);
    chk("midrst_no_dok", bus.inst_sram_data_ok, 0);

    // Recovery fetch
    cyc(1, 1, 32'h8000_0044, 1, 0, '0, 0);
    cyc(1, 0, 32'h0, 1, 0, '0, 0);
    chk("rec_araddr", bus.axi_araddr, 32'h8000_0040);
    cyc(1, 0, 32'h0, 0, 1, D7, 0);
    cyc(1, 0, 32'h0, 0, 0, '0, 0);
    chk("rec_dok", bus.inst_sram_data_ok, 1);
    chk("rec_rdata", bus.inst_sram_rdata, D7);
    cyc(1, 0, 32'h0, 0, 0, '0, 0);
    chk("dok_count", dok_seen, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
